// File: rtl/t05_huffman_decoder.sv
// t05_huffman_decoder: walks a Huffman tree one code bit per level and emits leaf characters.
// Define T05_DECODE_ERR_EN to stop in ERR on an internal node that has a zero child index.
module t05_huffman_decoder (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [31:0] totChar,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [8:0]  node_addr,
  output logic        node_req,
  input  logic        node_ack,
  input  logic [18:0] node_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_BIT, EMIT, DONE
`ifdef T05_DECODE_ERR_EN
    , ERR
`endif
  } state_t;
  state_t state_q, state_d;
  logic [8:0] cur_q, cur_d;
  logic [31:0] cnt_q, cnt_d, tot_q, tot_d;
  logic [17:0] nd_q, nd_d;
  logic skip_q, skip_d;
  logic bit_ready_q, node_req_q, char_valid_q, done_q;
  assign bit_ready = bit_ready_q;
  assign node_req = node_req_q;
  assign char_valid = char_valid_q;
  assign done = done_q;
  assign node_addr = cur_q;
  assign char_out = nd_q[7:0];
  // skip_q marks a root leaf: one code bit is swallowed before that symbol is emitted
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    tot_d = tot_q;
    nd_d = nd_q;
    skip_d = skip_q;
    case (state_q)
      FETCH: if (node_ack) begin
        nd_d = node_data[17:0];
        skip_d = node_data[18] && cur_q == 9'd0;
        state_d = (node_data[18] && cur_q != 9'd0) ? EMIT : WAIT_BIT;
`ifdef T05_DECODE_ERR_EN
        if (!node_data[18] && (node_data[17:9] == 9'd0 || node_data[8:0] == 9'd0)) state_d = ERR;
`endif
      end
      WAIT_BIT: if (bit_valid) begin
        skip_d = 1'b0;
        cur_d = skip_q ? cur_q : (bit_in ? nd_q[8:0] : nd_q[17:9]);
        state_d = skip_q ? EMIT : FETCH;
      end
      EMIT: if (char_ready) begin
        cnt_d = cnt_q + 32'd1;
        cur_d = 9'd0;
        state_d = (cnt_d == tot_q) ? DONE : FETCH;
      end
      default: if (start) begin
        tot_d = totChar;
        cnt_d = 32'd0;
        cur_d = 9'd0;
        skip_d = 1'b0;
        state_d = (totChar == 32'd0) ? DONE : FETCH;
      end
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cur_q <= 9'd0;
      cnt_q <= 32'd0;
      tot_q <= 32'd0;
      nd_q <= 18'd0;
      skip_q <= 1'b0;
      bit_ready_q <= 1'b0;
      node_req_q <= 1'b0;
      char_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      nd_q <= nd_d;
      skip_q <= skip_d;
      bit_ready_q <= state_d == WAIT_BIT;
      node_req_q <= state_d == FETCH;
      char_valid_q <= state_d == EMIT;
      done_q <= state_d == DONE;
    end
  end
`ifdef T05_DECODE_ERR_EN
  logic err_q;
  assign err = err_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else err_q <= state_d == ERR;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_t05_huffman_decoder.sv
// tb_t05_huffman_decoder: table-driven decode runs against behavioural tree/bit/char responders.
module tb_t05_huffman_decoder;
  logic clk = 1'b0, nrst, start, bit_in, bit_valid, bit_ready, node_req, node_ack;
  logic char_valid, char_ready, done, err;
  logic [31:0] totChar;
  logic [8:0] node_addr;
  logic [18:0] node_data;
  logic [7:0] char_out;
  t05_huffman_decoder dut (
    .clk(clk), .nrst(nrst), .start(start), .totChar(totChar),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .node_addr(node_addr), .node_req(node_req), .node_ack(node_ack), .node_data(node_data),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .done(done), .err(err)
  );
  always #5 clk = ~clk;

  logic [18:0] tree [0:511];
  logic [31:0] bits_v;
  int nbits, ack_dly, rdy_dly;
  int bidx, nw, cw, rx_n, nreq_cnt, brdy_cnt, stab;
  bit btook, ctook;
  logic [8:0] aprev;
  logic [7:0] cprev;
  logic [7:0] rx_c [0:15];
  int n_chk = 0, n_fail = 0;

  // Responders act on the falling edge; the DUT only changes on the rising edge.
  always @(negedge clk) begin
    if (!nrst) begin
      bidx = 0; nw = 0; cw = 0; rx_n = 0; nreq_cnt = 0; brdy_cnt = 0; stab = 0;
      btook = 0; ctook = 0; aprev = 0; cprev = 0;
      bit_valid = 0; bit_in = 0; node_ack = 0; node_data = 0; char_ready = 0;
    end else begin
      if (btook) bidx++;
      bit_valid = bidx < nbits;
      bit_in = (bidx < 32) ? bits_v[bidx] : 1'b0;
      btook = bit_valid && bit_ready;
      if (bit_ready) brdy_cnt++;
      if (ctook) begin
        if (rx_n < 16) rx_c[rx_n] = cprev;
        rx_n++;
        cw = 0;
      end
      if (node_req) begin
        if (nw > 0 && node_addr != aprev) stab++;
        aprev = node_addr;
        node_ack = nw >= ack_dly;
        node_data = tree[node_addr];
        nw++;
        nreq_cnt++;
      end else begin
        nw = 0;
        node_ack = 0;
      end
      if (char_valid) begin
        if (cw > 0 && char_out != cprev) stab++;
        cprev = char_out;
        char_ready = cw >= rdy_dly;
        cw++;
      end else begin
        cw = 0;
        char_ready = 0;
      end
      ctook = char_valid && char_ready;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] nd(input int l, input int r);
    return {1'b0, l[8:0], r[8:0]};
  endfunction
  function automatic logic [18:0] lf(input int c);
    return {1'b1, 10'd0, c[7:0]};
  endfunction

  task automatic load_tree(input int sel);
    for (int i = 0; i < 512; i++) tree[i] = 19'd0;
    if (sel == 1) tree[0] = lf(90);
    else begin
      tree[0] = nd(1, 2); tree[1] = lf(65); tree[2] = (sel == 2) ? nd(0, 4) : nd(3, 4);
      tree[3] = lf(66); tree[4] = lf(67);
    end
  endtask

  task automatic load_bits(input string s);
    bits_v = 32'd0;
    nbits = s.len();
    for (int i = 0; i < s.len(); i++) bits_v[i] = (s[i] == 8'h31);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #2 nrst = 0;
    #1 chk("reset_outputs", {bit_ready, node_req, char_valid, done, err, node_addr, char_out}, 64'd0);
    @(posedge clk); @(posedge clk); #2 nrst = 1;
  endtask

  task automatic do_start(input logic [31:0] t);
    @(posedge clk); #2 totChar = t; start = 1;
    @(posedge clk); #2 start = 0;
  endtask

  task automatic wait_end(input int budget);
    for (int c = 0; c < budget && !(done || err); c++) begin
      @(posedge clk); #2;
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  typedef struct {
    int tree_sel; logic [31:0] tot; string bits; int ack_d; int rdy_d; bit mid_start;
    string exp; int exp_bits; bit exp_done; bit exp_err;
  } vec_t;
  vec_t v [7];

  initial begin
    nrst = 0; start = 0; totChar = 0; nbits = 0; bits_v = 0; ack_dly = 0; rdy_dly = 0;
    v[0] = '{0, 32'd3, "010110", 0, 0, 1'b0, "ABC", 5, 1'b1, 1'b0};
    v[1] = '{0, 32'd3, "010110", 3, 4, 1'b1, "ABC", 5, 1'b1, 1'b0};
    v[2] = '{0, 32'd0, "0", 0, 0, 1'b0, "", 0, 1'b1, 1'b0};
    v[3] = '{1, 32'd2, "101", 0, 0, 1'b0, "ZZ", 2, 1'b1, 1'b0};
    v[4] = '{0, 32'd4, "1110010", 1, 1, 1'b0, "CBAB", 7, 1'b1, 1'b0};
`ifdef T05_DECODE_ERR_EN
    v[5] = '{2, 32'd3, "10", 0, 0, 1'b0, "", 1, 1'b0, 1'b1};
`else
    v[5] = '{2, 32'd3, "10", 0, 0, 1'b0, "", 2, 1'b0, 1'b0};
`endif
    v[6] = '{1, 32'hFFFFFFFF, "111", 0, 0, 1'b0, "ZZZ", 3, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      rst_pulse();
      load_tree(v[k].tree_sel);
      load_bits(v[k].bits);
      ack_dly = v[k].ack_d;
      rdy_dly = v[k].rdy_d;
      do_start(v[k].tot);
      if (v[k].mid_start) begin
        repeat (4) @(posedge clk);
        #2 totChar = 0; start = 1;
        @(posedge clk); #2 start = 0;
      end
      wait_end(300);
      chk($sformatf("v%0d_nchars", k), rx_n, v[k].exp.len());
      for (int i = 0; i < v[k].exp.len() && i < 16; i++)
        chk($sformatf("v%0d_char%0d", k, i), rx_c[i], v[k].exp[i]);
      chk($sformatf("v%0d_bits_used", k), bidx, v[k].exp_bits);
      chk($sformatf("v%0d_done", k), done, v[k].exp_done);
      chk($sformatf("v%0d_err", k), err, v[k].exp_err);
      chk($sformatf("v%0d_stable", k), stab, 0);
      if (v[k].tot == 0) begin
        chk($sformatf("v%0d_no_node_req", k), nreq_cnt, 0);
        chk($sformatf("v%0d_no_bit_ready", k), brdy_cnt, 0);
      end
    end
    // zero-length run: done visible one cycle after the start edge, and held
    rst_pulse();
    load_tree(0);
    load_bits("");
    do_start(0);
    chk("zero_done_t1", done, 1);
    @(posedge clk); #2;
    chk("zero_done_t2", done, 1);
    chk("zero_no_req", node_req | bit_ready, 0);
    // reset mid-run, then a fresh one-character run
    rst_pulse();
    load_bits("01011");
    do_start(3);
    for (int c = 0; c < 100 && rx_n < 1; c++) begin
      @(posedge clk); #2;
    end
    chk("midrun_first_char", rx_n, 1);
    @(posedge clk); #2 nrst = 0;
    #1 chk("midrun_reset_outputs", {bit_ready, node_req, char_valid, done, err, node_addr, char_out}, 64'd0);
    @(posedge clk); @(posedge clk); #2;
    load_bits("0");
    nrst = 1;
    repeat (4) @(posedge clk);
    #2;
    chk("post_reset_no_req", nreq_cnt, 0);
    chk("post_reset_no_bit", brdy_cnt, 0);
    chk("post_reset_idle", {done, node_req, bit_ready, char_valid}, 0);
    do_start(1);
    wait_end(100);
    chk("fresh_nchars", rx_n, 1);
    chk("fresh_char", rx_c[0], 65);
    chk("fresh_bits", bidx, 1);
    chk("fresh_done", done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
